uvma_st_slv: RTL and testbench
==============================

UVMA_ST_SLV -- requirements
Module: uvma_st_slv

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, giving the payload width in bits (legal 1..256).
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 4, giving the receive buffer entries (power of two, 2..64).
REQ-003 The module SHALL have parameter CNT_WIDTH, default 16, giving the width of the accepted-transaction counter.
REQ-004 Port: clk  input  1  sole clock; all logic samples on its rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: vld  input  1  initiator asserts when data is valid.
REQ-007 Port: rdy  output  1  responder can accept a beat.
REQ-008 Port: data  input  DATA_WIDTH  initiator payload.
REQ-009 Port: out_vld  output  1  buffered beat available to the downstream consumer.
REQ-010 Port: out_rdy  input  1  consumer accepts the buffered beat.
REQ-011 Port: out_data  output  DATA_WIDTH  oldest buffered payload.
REQ-012 Port: level  output  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-013 Port: acc_cnt  output  CNT_WIDTH  accepted beats, saturating.
REQ-014 Port: err  output  1  sticky protocol-violation flag; present only when the macro in REQ-029 is defined.

Function
REQ-015 An input beat SHALL be accepted on each rising edge where vld and rdy are both 1.
REQ-016 rdy SHALL equal (level < FIFO_DEPTH) combinationally from registered state, with no dependence on vld.
REQ-017 An accepted beat SHALL appear on out_data/out_vld no earlier than the cycle after acceptance (one-cycle latency when the buffer was empty).
REQ-018 out_vld SHALL equal (level != 0), and out_data SHALL hold the oldest unpopped entry, stable while out_vld=1 and out_rdy=0.
REQ-019 A pop SHALL occur on each edge where out_vld and out_rdy are both 1.
REQ-020 When a push and a pop occur on the same edge, level SHALL remain unchanged and ordering SHALL be preserved.
REQ-021 When full, rdy SHALL be 0, and vld SHALL have no effect on state.
REQ-022 When empty, out_rdy SHALL have no effect on state.
REQ-023 Read and write pointers SHALL wrap modulo FIFO_DEPTH without gaps or duplication.
REQ-024 acc_cnt SHALL increment by one per accepted beat and hold at 2^CNT_WIDTH-1 without wrapping.

Reset
REQ-025 While reset=1 at a clock edge, level, pointers, and acc_cnt SHALL clear to 0; err SHALL clear to 0 when present.
REQ-026 During reset and in the cycle following it, rdy SHALL be 1 and out_vld SHALL be 0; rdy SHALL be 1 in all cycles after reset until the buffer fills.
REQ-027 A reset asserted mid-operation SHALL discard all buffered beats, and no beat SHALL be accepted on an edge where reset=1.
REQ-028 Buffer storage contents SHALL NOT require a reset value.

Configuration
REQ-029 With UVMA_ST_SLV_PROTOCOL_CHK_EN defined, the module SHALL register vld and data each cycle and SHALL set err when, in the previous cycle, vld=1 and rdy=0, and in the current cycle vld=0 or data differs from the registered value (withdrawal or payload change under backpressure).
REQ-030 err SHALL be sticky until reset.
REQ-031 Without UVMA_ST_SLV_PROTOCOL_CHK_EN, the err port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Single beat: reset, then vld=1 with data=0xA5A5_0001 for one cycle, out_rdy=1 -> rdy=1; out_vld=1 with out_data=0xA5A5_0001 on the next cycle; acc_cnt=1; level returns to 0.
REQ-033 Fill: out_rdy=0, push 5 beats 1..5 with FIFO_DEPTH=4 -> beats 1..4 accepted; rdy=0 after the 4th; level=4; beat 5 held; after out_rdy=1, outputs in order 1,2,3,4,5.
REQ-034 Simultaneous push/pop: level=2, vld=1 and out_rdy=1 for 10 cycles with data incrementing -> level stays 2 and output order is strictly incrementing.
REQ-035 Mid-operation reset: level=3, assert reset for 1 cycle -> level=0, out_vld=0, rdy=1, acc_cnt=0; the next beat pushed is the first beat out.
REQ-036 Saturation: CNT_WIDTH=4, push 20 beats -> acc_cnt stops at 15.
REQ-037 Protocol check (macro defined): with rdy=0 and vld=1 with data=0x10, change data to 0x11 -> err=1 next cycle and err stays 1 until reset; with the macro undefined, the same stimulus produces no error port and normal buffering.

Source files
------------

// File: rtl/uvma_st_slv.sv
// Valid/ready stream responder: buffers accepted beats in a FIFO_DEPTH-entry FIFO and counts accepted beats.
// Optional protocol checker (sticky err port) is enabled by defining UVMA_ST_SLV_PROTOCOL_CHK_EN.
module uvma_st_slv #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          vld,
  output logic                          rdy,
  input  logic [DATA_WIDTH-1:0]         data,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic [CNT_WIDTH-1:0]          acc_cnt
`ifdef UVMA_ST_SLV_PROTOCOL_CHK_EN
  ,
  output logic                          err
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wptr, rptr;
  logic                  push, pop;

  assign rdy      = (level < FULL_LVL);
  assign out_vld  = (level != '0);
  assign out_data = mem[rptr];
  assign push     = vld && rdy;
  assign pop      = out_vld && out_rdy;

  // Power-of-two depth: pointers wrap naturally by overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      acc_cnt <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push && acc_cnt != '1) acc_cnt <= acc_cnt + 1'b1;
    end
  end

  // Storage carries no reset; a write during reset is harmless since pointers clear.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wptr] <= data;
  end

`ifdef UVMA_ST_SLV_PROTOCOL_CHK_EN
  logic                  vld_q, rdy_q;
  logic [DATA_WIDTH-1:0] data_q;

  // A beat offered under backpressure must stay offered with the same payload.
  always_ff @(posedge clk) begin
    data_q <= data;
    if (reset) begin
      vld_q <= 1'b0;
      rdy_q <= 1'b1;
      err   <= 1'b0;
    end else begin
      vld_q <= vld;
      rdy_q <= rdy;
      if (vld_q && !rdy_q && (!vld || data != data_q)) err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uvma_st_slv.sv
// Randomized self-checking bench for uvma_st_slv against a queue-based reference model.
module tb_uvma_st_slv;
  localparam int DW = 32, DEPTH = 4, CW = 4;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 0, reset = 1, vld = 0, out_rdy = 0;
  logic [DW-1:0] data = '0;
  logic          rdy, out_vld;
  logic [DW-1:0] out_data;
  logic [LW-1:0] level;
  logic [CW-1:0] acc_cnt;
`ifdef UVMA_ST_SLV_PROTOCOL_CHK_EN
  logic          err;
`endif

  int total = 0, bad = 0;
  logic [DW-1:0] q[$];
  int mcnt = 0;

  uvma_st_slv #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .vld(vld), .rdy(rdy), .data(data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .level(level), .acc_cnt(acc_cnt)
`ifdef UVMA_ST_SLV_PROTOCOL_CHK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock and apply the stream rules to the model queue.
  task automatic tick();
    bit push, pop;
    logic [DW-1:0] d;
    d    = data;
    push = !reset && vld && (q.size() < DEPTH);
    pop  = !reset && (q.size() != 0) && out_rdy;
    @(posedge clk); #1;
    if (reset) begin
      q.delete(); mcnt = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(d);
        if (mcnt < CMAX) mcnt++;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1; vld = 0; out_rdy = 0;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (level !== '0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b exp=1", rdy); end
    total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL reset_out_vld got=%b exp=0", out_vld); end
    total++; if (acc_cnt !== '0) begin bad++; $display("FAIL reset_acc_cnt got=%0d exp=0", acc_cnt); end
  endtask

  task automatic test_single_beat();
    do_reset();
    out_rdy = 1; vld = 1; data = 32'hA5A5_0001;
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL single_rdy got=%b exp=1", rdy); end
    tick();
    vld = 0;
    total++; if (out_vld !== 1'b1 || out_data !== 32'hA5A5_0001)
      begin bad++; $display("FAIL single_out got=%b/%h exp=1/a5a50001", out_vld, out_data); end
    total++; if (acc_cnt !== 4'd1) begin bad++; $display("FAIL single_acc got=%0d exp=1", acc_cnt); end
    tick();
    total++; if (level !== '0) begin bad++; $display("FAIL single_level got=%0d exp=0", level); end
  endtask

  task automatic test_fill();
    logic [DW-1:0] got[$];
    int n;
    do_reset();
    for (int i = 1; i <= 4; i++) begin vld = 1; data = DW'(i); tick(); end
    data = 5;
    total++; if (level !== LW'(4) || rdy !== 1'b0)
      begin bad++; $display("FAIL fill_full got=%0d/%b exp=4/0", level, rdy); end
    tick(); tick();
    total++; if (level !== LW'(4) || out_data !== 32'd1)
      begin bad++; $display("FAIL fill_hold got=%0d/%0d exp=4/1", level, out_data); end
    out_rdy = 1;
    n = 0;
    while (got.size() < 5 && n < 20) begin
      bit acc;
      acc = vld && rdy;
      if (out_vld) got.push_back(out_data);
      tick();
      if (acc) vld = 0;
      n++;
    end
    total++; if (got.size() != 5) begin bad++; $display("FAIL fill_timeout got=%0d exp=5", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      total++; if (got[i] !== DW'(i + 1)) begin bad++; $display("FAIL fill_order[%0d] got=%0d exp=%0d", i, got[i], i + 1); end
    end
    out_rdy = 0;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_out;
    do_reset();
    vld = 1; data = 100; tick(); data = 101; tick();
    exp_out = 100;
    out_rdy = 1;
    for (int i = 0; i < 10; i++) begin
      data = DW'(102 + i);
      total++; if (out_data !== exp_out) begin bad++; $display("FAIL b2b_out got=%0d exp=%0d", out_data, exp_out); end
      tick();
      exp_out++;
      total++; if (level !== LW'(2)) begin bad++; $display("FAIL b2b_level got=%0d exp=2", level); end
    end
    vld = 0; out_rdy = 0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    vld = 1;
    for (int i = 0; i < 3; i++) begin data = $urandom; tick(); end
    vld = 0;
    total++; if (level !== LW'(3)) begin bad++; $display("FAIL mreset_pre got=%0d exp=3", level); end
    reset = 1; vld = 1; data = 32'hDEAD_BEEF; tick(); reset = 0; vld = 0;
    total++; if (level !== '0 || out_vld !== 1'b0 || rdy !== 1'b1 || acc_cnt !== '0)
      begin bad++; $display("FAIL mreset_state got=%0d/%b/%b/%0d exp=0/0/1/0", level, out_vld, rdy, acc_cnt); end
    vld = 1; data = 32'h0000_0077; tick(); vld = 0;
    total++; if (out_vld !== 1'b1 || out_data !== 32'h77)
      begin bad++; $display("FAIL mreset_first got=%b/%h exp=1/77", out_vld, out_data); end
  endtask

  task automatic test_saturation();
    do_reset();
    vld = 1; out_rdy = 1;
    for (int i = 0; i < 20; i++) begin data = DW'(i); tick(); end
    vld = 0; out_rdy = 0;
    total++; if (acc_cnt !== CW'(mcnt) || mcnt != CMAX)
      begin bad++; $display("FAIL sat_acc got=%0d exp=%0d", acc_cnt, CMAX); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      vld = ($urandom_range(0, 3) != 0);
      out_rdy = ($urandom_range(0, 2) != 0);
      data = $urandom;
      if (i % 97 == 50) reset = 1; else reset = 0;
      tick();
      reset = 0;
      total++; if (level !== LW'(q.size()) || rdy !== (q.size() < DEPTH) || out_vld !== (q.size() != 0)
                   || acc_cnt !== CW'(mcnt))
        begin bad++; $display("FAIL rand_state cyc=%0d got=%0d/%b/%b/%0d exp=%0d/%0d", i, level, rdy, out_vld, acc_cnt, q.size(), mcnt); end
      if (q.size() != 0) begin
        total++; if (out_data !== q[0]) begin bad++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", i, out_data, q[0]); end
      end
    end
    vld = 0; out_rdy = 0;
  endtask

  task automatic test_protocol();
    do_reset();
    vld = 1;
    for (int i = 0; i < 4; i++) begin data = DW'(i); tick(); end
    data = 32'h10; tick(); tick();
`ifdef UVMA_ST_SLV_PROTOCOL_CHK_EN
    total++; if (err !== 1'b0) begin bad++; $display("FAIL proto_clean got=%b exp=0", err); end
    data = 32'h11; tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL proto_set got=%b exp=1", err); end
    vld = 0; tick(); tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL proto_sticky got=%b exp=1", err); end
    do_reset();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL proto_reset got=%b exp=0", err); end
`else
    data = 32'h11; tick();
    total++; if (level !== LW'(4) || out_data !== 32'd0)
      begin bad++; $display("FAIL proto_nochk got=%0d/%0d exp=4/0", level, out_data); end
    vld = 0; out_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      total++; if (out_data !== DW'(i)) begin bad++; $display("FAIL proto_drain got=%0d exp=%0d", out_data, i); end
      tick();
    end
    out_rdy = 0;
`endif
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_fill();
    test_back_to_back();
    test_mid_reset();
    test_saturation();
    test_random();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
